// File: rtl/intc_arbiter.sv
// -----------------------------------------------------------------------------
// intc_arbiter
//   Priority arbiter and vector sequencer for the interrupt path. Selects one
//   winner among NMI and NSRC maskable sources against the CPU mask, offers it
//   to the CPU, obtains its vector (internal register or external VBUS fetch
//   with timeout), and returns a one-hot accept pulse on CPU acknowledge.
//
// Ports
//   CLK, RST_N, CE        clock, synchronous active-low reset, clock enable
//   NMI_REQ / NMI_ACK     unmaskable request (level F, vector 11) / accept pulse
//   SRC_IRQ/LVL/VEC/EXT   per-source request, level, internal vector, ext flag
//   SRC_ACK               one-hot accept pulse to the winning source
//   INT_MASK              CPU interrupt mask (SR.I3-0)
//   INT_REQ/LVL/VEC       interrupt offered to the CPU
//   VECT_REQ / VECT_WAIT  CPU vector request / stall while vector pending
//   INT_ACK               CPU has accepted the interrupt
//   VBUS_A/REQ/DI/WAIT    external vector fetch bus
//
// States
//   ST_IDLE   | arbitrating every CE cycle, nothing offered
//   ST_OFFER  | winner latched and offered, waiting for VECT_REQ
//   ST_VFETCH | external vector fetch in progress on VBUS
//   ST_VDONE  | vector valid, waiting for INT_ACK
// -----------------------------------------------------------------------------
module intc_arbiter #(
  parameter int         NSRC     = 16,
  parameter int         TO_CYC   = 255,
  parameter logic [7:0] SPUR_VEC = 8'd24
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic              NMI_REQ,
  output logic              NMI_ACK,
  input  logic [NSRC-1:0]   SRC_IRQ,
  input  logic [4*NSRC-1:0] SRC_LVL,
  input  logic [8*NSRC-1:0] SRC_VEC,
  input  logic [NSRC-1:0]   SRC_EXT,
  output logic [NSRC-1:0]   SRC_ACK,
  input  logic [3:0]        INT_MASK,
  output logic              INT_REQ,
  output logic [3:0]        INT_LVL,
  output logic [7:0]        INT_VEC,
  input  logic              VECT_REQ,
  output logic              VECT_WAIT,
  input  logic              INT_ACK,
  output logic [3:0]        VBUS_A,
  output logic              VBUS_REQ,
  input  logic [7:0]        VBUS_DI,
  input  logic              VBUS_WAIT
);

  localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OFFER  = 2'd1;
  localparam logic [1:0] ST_VFETCH = 2'd2;
  localparam logic [1:0] ST_VDONE  = 2'd3;

  localparam logic [3:0] NMI_LVL = 4'hF;
  localparam logic [7:0] NMI_VEC = 8'd11;
  localparam logic [7:0] TO_CNT  = 8'(TO_CYC);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            nmi_q, nmi_d;
  logic            ext_q, ext_d;
  logic [7:0]      vec_q, vec_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            int_req_q, int_req_d;
  logic [3:0]      int_lvl_q, int_lvl_d;
  logic [7:0]      int_vec_q, int_vec_d;
  logic            vect_wait_q, vect_wait_d;
  logic            vbus_req_q, vbus_req_d;
  logic [3:0]      vbus_a_q, vbus_a_d;
  logic [NSRC-1:0] src_ack_q, src_ack_d;
  logic            nmi_ack_q, nmi_ack_d;

  logic            arb_found;
  logic [IDXW-1:0] arb_idx;
  logic [3:0]      arb_lvl;
  logic [7:0]      arb_vec;
  logic            arb_ext;

  // Strictly-greater compare keeps the lowest index on a level tie; starting
  // from level 0 also means a level-0 source can never win.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_lvl   = 4'd0;
    arb_vec   = 8'd0;
    arb_ext   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (SRC_IRQ[i] && (SRC_LVL[4*i +: 4] > INT_MASK) &&
          (SRC_LVL[4*i +: 4] > arb_lvl)) begin
        arb_found = 1'b1;
        arb_idx   = IDXW'(i);
        arb_lvl   = SRC_LVL[4*i +: 4];
        arb_vec   = SRC_VEC[8*i +: 8];
        arb_ext   = SRC_EXT[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    nmi_d       = nmi_q;
    ext_d       = ext_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    int_req_d   = int_req_q;
    int_lvl_d   = int_lvl_q;
    int_vec_d   = int_vec_q;
    vect_wait_d = vect_wait_q;
    vbus_req_d  = vbus_req_q;
    vbus_a_d    = vbus_a_q;
    src_ack_d   = src_ack_q;
    nmi_ack_d   = nmi_ack_q;

    if (CE) begin
      // accept pulses last exactly one CE cycle
      src_ack_d = '0;
      nmi_ack_d = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (NMI_REQ) begin
            nmi_d     = 1'b1;
            ext_d     = 1'b0;
            idx_d     = '0;
            vec_d     = NMI_VEC;
            int_lvl_d = NMI_LVL;
            int_vec_d = 8'd0;
            int_req_d = 1'b1;
            state_d   = ST_OFFER;
          end else if (arb_found) begin
            nmi_d     = 1'b0;
            ext_d     = arb_ext;
            idx_d     = arb_idx;
            vec_d     = arb_vec;
            int_lvl_d = arb_lvl;
            int_vec_d = 8'd0;
            int_req_d = 1'b1;
            state_d   = ST_OFFER;
          end
        end

        ST_OFFER: begin
          // VECT_REQ takes precedence over a same-cycle request withdrawal
          if (VECT_REQ) begin
            if (ext_q) begin
              vbus_req_d  = 1'b1;
              vbus_a_d    = int_lvl_q;
              vect_wait_d = 1'b1;
              cnt_d       = 8'd0;
              state_d     = ST_VFETCH;
            end else begin
              int_vec_d = vec_q;
              state_d   = ST_VDONE;
            end
          end else if (!nmi_q && !SRC_IRQ[idx_q]) begin
            int_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end

        ST_VFETCH: begin
          // ready data wins even on the terminal-count cycle
          if (!VBUS_WAIT) begin
            int_vec_d   = VBUS_DI;
            vbus_req_d  = 1'b0;
            vect_wait_d = 1'b0;
            state_d     = ST_VDONE;
          end else if (cnt_q == TO_CNT) begin
            int_vec_d   = SPUR_VEC;
            vbus_req_d  = 1'b0;
            vect_wait_d = 1'b0;
            state_d     = ST_VDONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        ST_VDONE: begin
          if (INT_ACK) begin
            if (nmi_q) begin
              nmi_ack_d = 1'b1;
            end else begin
              src_ack_d = NSRC'(1) << idx_q;
            end
            int_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      nmi_q       <= 1'b0;
      ext_q       <= 1'b0;
      vec_q       <= 8'd0;
      cnt_q       <= 8'd0;
      int_req_q   <= 1'b0;
      int_lvl_q   <= 4'd0;
      int_vec_q   <= 8'd0;
      vect_wait_q <= 1'b0;
      vbus_req_q  <= 1'b0;
      vbus_a_q    <= 4'd0;
      src_ack_q   <= '0;
      nmi_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      nmi_q       <= nmi_d;
      ext_q       <= ext_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      int_req_q   <= int_req_d;
      int_lvl_q   <= int_lvl_d;
      int_vec_q   <= int_vec_d;
      vect_wait_q <= vect_wait_d;
      vbus_req_q  <= vbus_req_d;
      vbus_a_q    <= vbus_a_d;
      src_ack_q   <= src_ack_d;
      nmi_ack_q   <= nmi_ack_d;
    end
  end

  assign NMI_ACK   = nmi_ack_q;
  assign SRC_ACK   = src_ack_q;
  assign INT_REQ   = int_req_q;
  assign INT_LVL   = int_lvl_q;
  assign INT_VEC   = int_vec_q;
  assign VECT_WAIT = vect_wait_q;
  assign VBUS_A    = vbus_a_q;
  assign VBUS_REQ  = vbus_req_q;

endmodule

// File: tb/tb_intc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_intc_arbiter
//   Scenario bench for intc_arbiter: directed sequences for each behaviour plus
//   a randomized arbitration loop checked against a level-scan reference model.
// -----------------------------------------------------------------------------
module tb_intc_arbiter;

  localparam int NSRC   = 16;
  localparam int TO_CYC = 255;
  localparam logic [7:0] SPUR = 8'd24;

  logic        clk = 1'b0;
  logic        rst_n, ce, nmi_req, nmi_ack;
  logic [15:0] src_irq, src_ext, src_ack;
  logic [63:0] src_lvl;
  logic [127:0] src_vec;
  logic [3:0]  int_mask, int_lvl, vbus_a;
  logic        int_req, vect_req, vect_wait, int_ack, vbus_req, vbus_wait;
  logic [7:0]  int_vec, vbus_di;

  int errors = 0;
  int checks = 0;

  intc_arbiter #(.NSRC(NSRC), .TO_CYC(TO_CYC), .SPUR_VEC(SPUR)) dut (
    .CLK(clk), .RST_N(rst_n), .CE(ce),
    .NMI_REQ(nmi_req), .NMI_ACK(nmi_ack),
    .SRC_IRQ(src_irq), .SRC_LVL(src_lvl), .SRC_VEC(src_vec), .SRC_EXT(src_ext),
    .SRC_ACK(src_ack), .INT_MASK(int_mask),
    .INT_REQ(int_req), .INT_LVL(int_lvl), .INT_VEC(int_vec),
    .VECT_REQ(vect_req), .VECT_WAIT(vect_wait), .INT_ACK(int_ack),
    .VBUS_A(vbus_a), .VBUS_REQ(vbus_req), .VBUS_DI(vbus_di), .VBUS_WAIT(vbus_wait)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst_n = 1'b1; ce = 1'b1; nmi_req = 1'b0;
    src_irq = '0; src_lvl = '0; src_vec = '0; src_ext = '0;
    int_mask = 4'd0; vect_req = 1'b0; int_ack = 1'b0;
    vbus_di = 8'd0; vbus_wait = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [3:0] l, input logic [7:0] v, input logic e);
    src_lvl[4*i +: 4] = l;
    src_vec[8*i +: 8] = v;
    src_ext[i] = e;
  endtask

  // Reference: scan levels from highest down to mask+1; within a level the
  // first requesting index found wins. NMI beats everything. NSRC = NMI, -1 = none.
  function automatic int ref_winner(input logic nmi, input logic [15:0] irq,
                                    input logic [63:0] lvl, input logic [3:0] mask);
    if (nmi) return NSRC;
    for (int l = 15; l > int'(mask); l--)
      for (int i = 0; i < NSRC; i++)
        if (irq[i] && int'(lvl[4*i +: 4]) == l) return i;
    return -1;
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0; ce = 1'b0; nmi_req = 1'b1;
    tick(); tick();
    checks++;
    if ({nmi_ack, src_ack, int_req, int_lvl, int_vec, vect_wait, vbus_a, vbus_req} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b lvl=%h vec=%h ack=%h vbus_req=%b, required all 0",
               int_req, int_lvl, int_vec, src_ack, vbus_req);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_basic();
    clear_inputs();
    int_mask = 4'd5;
    set_src(3, 4'd9, 8'h40, 1'b0);
    src_irq[3] = 1'b1;
    tick();
    checks++;
    if (int_req !== 1'b1 || int_lvl !== 4'd9) begin
      errors++; $display("FAIL basic_offer: got req=%b lvl=%h, required req=1 lvl=9", int_req, int_lvl);
    end
    vect_req = 1'b1; tick(); vect_req = 1'b0;
    checks++;
    if (int_vec !== 8'h40 || vect_wait !== 1'b0) begin
      errors++; $display("FAIL basic_vec: got vec=%h wait=%b, required vec=40 wait=0", int_vec, vect_wait);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++;
    if (src_ack !== 16'h0008 || int_req !== 1'b0) begin
      errors++; $display("FAIL basic_ack: got ack=%h req=%b, required ack=0008 req=0", src_ack, int_req);
    end
    src_irq[3] = 1'b0;
    tick();
    checks++;
    if (src_ack !== 16'h0000) begin
      errors++; $display("FAIL basic_ack_pulse: got ack=%h one cycle later, required 0000", src_ack);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    int_mask = 4'd3;
    set_src(2, 4'd7, 8'h22, 1'b0);
    set_src(5, 4'd7, 8'h55, 1'b0);
    set_src(9, 4'd12, 8'h99, 1'b0);
    src_irq = 16'h0224;
    tick();
    checks++;
    if (int_req !== 1'b1 || int_lvl !== 4'd12) begin
      errors++; $display("FAIL prio_high: got req=%b lvl=%h, required req=1 lvl=c", int_req, int_lvl);
    end
    vect_req = 1'b1; tick(); vect_req = 1'b0;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++;
    if (src_ack !== 16'h0200 || int_req !== 1'b0) begin
      errors++; $display("FAIL prio_ack9: got ack=%h req=%b, required ack=0200 req=0", src_ack, int_req);
    end
    src_irq[9] = 1'b0;
    tick();
    checks++;
    if (int_req !== 1'b1 || int_lvl !== 4'd7) begin
      errors++; $display("FAIL prio_gap: got req=%b lvl=%h, required req=1 lvl=7 after one-cycle gap", int_req, int_lvl);
    end
    vect_req = 1'b1; tick(); vect_req = 1'b0;
    checks++;
    if (int_vec !== 8'h22) begin
      errors++; $display("FAIL prio_tie_vec: got vec=%h, required 22", int_vec);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++;
    if (src_ack !== 16'h0004) begin
      errors++; $display("FAIL prio_tie_ack: got ack=%h, required 0004", src_ack);
    end
    src_irq[2] = 1'b0;
    int_mask = 4'd7;
    repeat (4) tick();
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL prio_masked: got req=%b, required 0 with mask 7", int_req);
    end
  endtask

  task automatic test_nmi();
    clear_inputs();
    set_src(0, 4'd15, 8'h80, 1'b0);
    src_irq[0] = 1'b1;
    nmi_req = 1'b1;
    tick();
    checks++;
    if (int_req !== 1'b1 || int_lvl !== 4'hF) begin
      errors++; $display("FAIL nmi_offer: got req=%b lvl=%h, required req=1 lvl=f", int_req, int_lvl);
    end
    vect_req = 1'b1; tick(); vect_req = 1'b0;
    checks++;
    if (int_vec !== 8'd11) begin
      errors++; $display("FAIL nmi_vec: got vec=%0d, required 11", int_vec);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++;
    if (nmi_ack !== 1'b1 || src_ack !== 16'h0000) begin
      errors++; $display("FAIL nmi_ack: got nmi_ack=%b src_ack=%h, required 1 and 0000", nmi_ack, src_ack);
    end
    nmi_req = 1'b0; src_irq = '0;
    tick();
  endtask

  task automatic test_ext_fetch();
    int n;
    clear_inputs();
    set_src(1, 4'd6, 8'h00, 1'b1);
    vbus_wait = 1'b1;
    src_irq[1] = 1'b1;
    tick();
    vect_req = 1'b1; tick(); vect_req = 1'b0;
    checks++;
    if (vbus_req !== 1'b1 || vbus_a !== 4'd6 || vect_wait !== 1'b1) begin
      errors++; $display("FAIL ext_start: got vbus_req=%b vbus_a=%h wait=%b, required 1 6 1", vbus_req, vbus_a, vect_wait);
    end
    n = 0;
    while (vect_wait && n < 300) begin
      n++;
      if (n == 4) begin vbus_wait = 1'b0; vbus_di = 8'h71; end
      tick();
    end
    checks++;
    if (n != 4 || int_vec !== 8'h71 || vbus_req !== 1'b0) begin
      errors++; $display("FAIL ext_data: got wait_cycles=%0d vec=%h vbus_req=%b, required 4 71 0", n, int_vec, vbus_req);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++;
    if (src_ack !== 16'h0002) begin
      errors++; $display("FAIL ext_ack: got ack=%h, required 0002", src_ack);
    end
    tick();
    // WAIT stuck: spurious vector after TO_CYC+1 fetch cycles
    vbus_wait = 1'b1;
    tick();
    vect_req = 1'b1; tick(); vect_req = 1'b0;
    n = 0;
    while (vect_wait && n < 300) begin n++; tick(); end
    checks++;
    if (n != TO_CYC + 1 || int_vec !== SPUR || vbus_req !== 1'b0) begin
      errors++; $display("FAIL ext_timeout: got wait_cycles=%0d vec=%0d, required %0d and %0d", n, int_vec, TO_CYC + 1, SPUR);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tick();
    // data ready exactly on the terminal-count cycle is still used
    vect_req = 1'b1; tick(); vect_req = 1'b0;
    n = 0;
    while (vect_wait && n < 300) begin
      n++;
      if (n == TO_CYC + 1) begin vbus_wait = 1'b0; vbus_di = 8'h5A; end
      tick();
    end
    checks++;
    if (n != TO_CYC + 1 || int_vec !== 8'h5A) begin
      errors++; $display("FAIL ext_tc_data: got wait_cycles=%0d vec=%h, required %0d and 5a", n, int_vec, TO_CYC + 1);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    src_irq = '0;
    tick();
  endtask

  task automatic test_withdraw_reset();
    logic [15:0] acc;
    clear_inputs();
    set_src(4, 4'd5, 8'h44, 1'b0);
    src_irq[4] = 1'b1;
    tick();
    src_irq[4] = 1'b0;
    tick();
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL withdraw_req: got req=%b, required 0", int_req);
    end
    acc = src_ack;
    repeat (3) begin tick(); acc |= src_ack; end
    checks++;
    if (acc !== 16'h0000 || int_req !== 1'b0) begin
      errors++; $display("FAIL withdraw_noack: got ack=%h req=%b, required 0000 0", acc, int_req);
    end
    set_src(7, 4'd6, 8'h00, 1'b1);
    vbus_wait = 1'b1;
    src_irq[7] = 1'b1;
    tick();
    vect_req = 1'b1; tick(); vect_req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({nmi_ack, src_ack, int_req, int_lvl, int_vec, vect_wait, vbus_a, vbus_req} !== '0) begin
      errors++;
      $display("FAIL reset_in_fetch: got req=%b lvl=%h vbus_req=%b vbus_a=%h ack=%h, required all 0",
               int_req, int_lvl, vbus_req, vbus_a, src_ack);
    end
    clear_inputs();
    tick(); tick();
    checks++;
    if (src_ack !== 16'h0000 || int_req !== 1'b0) begin
      errors++; $display("FAIL reset_after: got ack=%h req=%b, required 0000 0", src_ack, int_req);
    end
  endtask

  task automatic test_ce_gating();
    logic        exp_req;
    logic [15:0] exp_ack;
    clear_inputs();
    int_mask = 4'd2;
    set_src(6, 4'd10, 8'h66, 1'b0);
    for (int step = 1; step <= 4; step++) begin
      ce = 1'b1; nmi_req = 1'b0; int_mask = 4'd2;
      src_irq = (step <= 3) ? 16'h0040 : 16'h0000;
      vect_req = (step == 2);
      int_ack  = (step == 3);
      exp_req = (step <= 2);
      exp_ack = (step == 3) ? 16'h0040 : 16'h0000;
      for (int k = 0; k < 3; k++) begin
        tick();
        checks++;
        if (int_req !== exp_req || src_ack !== exp_ack || nmi_ack !== 1'b0 || vect_wait !== 1'b0) begin
          errors++;
          $display("FAIL ce_step%0d_%0d: got req=%b ack=%h nmi_ack=%b wait=%b, required req=%b ack=%h",
                   step, k, int_req, src_ack, nmi_ack, vect_wait, exp_req, exp_ack);
        end
        if (step == 2) begin
          checks++;
          if (int_vec !== 8'h66 || int_lvl !== 4'd10) begin
            errors++; $display("FAIL ce_vec_%0d: got vec=%h lvl=%h, required 66 a", k, int_vec, int_lvl);
          end
        end
        // frozen cycles: inputs scrambled, must have no effect
        ce = 1'b0; nmi_req = 1'b1; int_ack = 1'b1; vect_req = 1'b1;
        src_irq = 16'hFFFF; int_mask = 4'd0;
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int w, n;
    logic [3:0]  exp_lvl;
    logic [7:0]  exp_vec;
    logic [15:0] exp_ack;
    for (int it = 0; it < 60; it++) begin
      clear_inputs();
      src_irq = 16'($urandom & $urandom);
      for (int i = 0; i < NSRC; i++)
        set_src(i, 4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
      int_mask = 4'($urandom_range(0, 12));
      nmi_req = ($urandom_range(0, 9) == 0);
      vbus_di = 8'($urandom);
      w = ref_winner(nmi_req, src_irq, src_lvl, int_mask);
      exp_ack = '0;
      if (w == NSRC) begin
        exp_lvl = 4'hF; exp_vec = 8'd11;
      end else if (w >= 0) begin
        exp_lvl = src_lvl[4*w +: 4];
        exp_vec = src_ext[w] ? vbus_di : src_vec[8*w +: 8];
        exp_ack[w] = 1'b1;
      end else begin
        exp_lvl = 4'd0; exp_vec = 8'd0;
      end
      tick();
      checks++;
      if (int_req !== (w >= 0) || (w >= 0 && int_lvl !== exp_lvl)) begin
        errors++;
        $display("FAIL rand_offer_%0d: got req=%b lvl=%h, required req=%b lvl=%h (winner %0d)",
                 it, int_req, int_lvl, (w >= 0), exp_lvl, w);
      end
      if (w >= 0) begin
        vect_req = 1'b1; tick(); vect_req = 1'b0;
        n = 0;
        while (vect_wait && n < 20) begin n++; tick(); end
        checks++;
        if (int_vec !== exp_vec || vect_wait !== 1'b0) begin
          errors++; $display("FAIL rand_vec_%0d: got vec=%h, required %h", it, int_vec, exp_vec);
        end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        checks++;
        if (src_ack !== exp_ack || nmi_ack !== (w == NSRC)) begin
          errors++;
          $display("FAIL rand_ack_%0d: got ack=%h nmi_ack=%b, required %h %b",
                   it, src_ack, nmi_ack, exp_ack, (w == NSRC));
        end
      end
      src_irq = '0; nmi_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_nmi();
    test_ext_fetch();
    test_withdraw_reset();
    test_ce_gating();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
